// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external ALU (OR/AND/ADD/SUB/MUL) between two
// requesters. Arbitration is round-robin, and each requester has a valid/ready
// handshake. Operands are registered and held on the ALU for the whole operation;
// a MUL is held for MUL_CYCLES cycles. The result is returned on one valid/ready
// response channel, tagged with the id of the requester that issued it.
//
// Ports:
//   clk_i, rst_i                   clock (rising edge), async active-high reset
//   reqN_valid_i / reqN_ready_o    request handshake, N = 0,1 (ready is combinational)
//   reqN_op_i, reqN_a_i, reqN_b_i  ALU control and operands per requester
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_id_o, rsp_data_o           issuing requester and result
//   rsp_err_o                      illegal-op flag (0 unless ALU_ARB_OPCHECK_EN)
//   alu_data1_o, alu_data2_o       ALU operands
//   alu_ctrl_o, alu_data_i         ALU control and ALU result
//   busy_o                         high whenever the FSM is not idle
//
// Optional feature macro: ALU_ARB_OPCHECK_EN. When it is defined, ops 101..111
// skip the ALU and are answered with data 0 and rsp_err_o = 1.
module alu_share_arbiter #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned WIDTH      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [2:0]       req0_op_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [2:0]       req1_op_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,
    output logic             busy_o
);

    localparam int unsigned CNT_W  = 4;
    localparam logic [2:0]  OP_MUL = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             last_grant;
    logic             id_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt;

    logic             gnt_any;
    logic             gnt_id;
    logic             accept;
    logic [2:0]       gnt_op;
    logic [WIDTH-1:0] gnt_a;
    logic [WIDTH-1:0] gnt_b;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    assign gnt_any = req0_valid_i | req1_valid_i;
    assign gnt_id  = (req0_valid_i & req1_valid_i) ? ~last_grant : req1_valid_i;
    assign accept  = (state == IDLE) & gnt_any;

    assign req0_ready_o = accept & ~gnt_id;
    assign req1_ready_o = accept &  gnt_id;

    assign gnt_op = gnt_id ? req1_op_i : req0_op_i;
    assign gnt_a  = gnt_id ? req1_a_i  : req0_a_i;
    assign gnt_b  = gnt_id ? req1_b_i  : req0_b_i;

    // The ALU sees only the registered operands, so its inputs are stable for the whole op.
    assign alu_ctrl_o  = op_q;
    assign alu_data1_o = a_q;
    assign alu_data2_o = b_q;
    assign busy_o      = (state != IDLE);

`ifdef ALU_ARB_OPCHECK_EN
    logic rsp_err_q;
    logic op_illegal;
    assign op_illegal = gnt_op[2] & (gnt_op[1:0] != 2'b00);
    assign rsp_err_o  = rsp_err_q;
`else
    assign rsp_err_o  = 1'b0;
`endif

    // Arbitration, operand capture, MUL hold counter and response register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_data_o  <= '0;
`ifdef ALU_ARB_OPCHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= gnt_id;
`ifdef ALU_ARB_OPCHECK_EN
                        // Illegal op: answer directly and leave the ALU inputs untouched.
                        if (op_illegal) begin
                            rsp_valid_o <= 1'b1;
                            rsp_id_o    <= gnt_id;
                            rsp_data_o  <= '0;
                            rsp_err_q   <= 1'b1;
                            state       <= RESP;
                        end else
`endif
                        begin
                            id_q  <= gnt_id;
                            op_q  <= gnt_op;
                            a_q   <= gnt_a;
                            b_q   <= gnt_b;
                            cnt   <= (gnt_op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_valid_o <= 1'b1;
                        rsp_id_o    <= id_q;
                        rsp_data_o  <= alu_data_i;
`ifdef ALU_ARB_OPCHECK_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= RESP;
                    end
                end
                RESP: begin
                    // Hold the response until the consumer takes it; nothing is accepted here.
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter. It contains a behavioural model of the
// external ALU, and each scenario task checks the DUT against hand-computed values.
module tb_alu_share_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req0_valid_i, req0_ready_o;
    logic [2:0]       req0_op_i;
    logic [WIDTH-1:0] req0_a_i, req0_b_i;
    logic             req1_valid_i, req1_ready_o;
    logic [2:0]       req1_op_i;
    logic [WIDTH-1:0] req1_a_i, req1_b_i;
    logic             rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o, busy_o;
    logic [WIDTH-1:0] rsp_data_o;
    logic [WIDTH-1:0] alu_data1_o, alu_data2_o, alu_data_i;
    logic [2:0]       alu_ctrl_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    alu_share_arbiter #(.MUL_CYCLES(3), .WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_op_i    (req0_op_i),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_op_i    (req1_op_i),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .alu_data1_o  (alu_data1_o),
        .alu_data2_o  (alu_data2_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_data_i   (alu_data_i),
        .busy_o       (busy_o)
    );

    // External ALU model; returns 0 for ops outside OR/AND/ADD/SUB/MUL.
    always_comb begin
        alu_data_i = '0;
        case (alu_ctrl_o)
            3'b000:  alu_data_i = alu_data1_o | alu_data2_o;
            3'b001:  alu_data_i = alu_data1_o & alu_data2_o;
            3'b010:  alu_data_i = alu_data1_o + alu_data2_o;
            3'b011:  alu_data_i = alu_data1_o - alu_data2_o;
            3'b100:  alu_data_i = WIDTH'(alu_data1_o * alu_data2_o);
            default: alu_data_i = '0;
        endcase
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        req0_valid_i = 1'b0; req0_op_i = '0; req0_a_i = '0; req0_b_i = '0;
        req1_valid_i = 1'b0; req1_op_i = '0; req1_a_i = '0; req1_b_i = '0;
        rsp_ready_i = 1'b1;
        #3;
        n_checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_err_o, busy_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {rsp_valid_o, rsp_id_o, rsp_err_o, busy_o});
        end
        n_checks++;
        if (rsp_data_o !== '0) begin
            n_fail++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data_o);
        end
        n_checks++;
        if ({alu_ctrl_o, alu_data1_o, alu_data2_o} !== '0) begin
            n_fail++; $display("FAIL reset_alu: got ctrl %0h d1 %0h d2 %0h want 0", alu_ctrl_o, alu_data1_o, alu_data2_o);
        end
        tick();
        rst_i = 1'b0;
        tick();
        n_checks++;
        if ({req0_ready_o, req1_ready_o, busy_o} !== 3'b000) begin
            n_fail++; $display("FAIL idle_no_req: got %b want 000", {req0_ready_o, req1_ready_o, busy_o});
        end
    endtask

    task automatic test_add;
        req0_valid_i = 1'b1; req0_op_i = 3'b010; req0_a_i = 32'd5; req0_b_i = 32'd7;
        #1;
        n_checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            n_fail++; $display("FAIL add_ready: got %b want 10", {req0_ready_o, req1_ready_o});
        end
        tick();
        req0_valid_i = 1'b0; req0_a_i = 32'd99;
        n_checks++;
        if ({busy_o, rsp_valid_o, alu_ctrl_o} !== 5'b10_010 || alu_data1_o !== 32'd5) begin
            n_fail++; $display("FAIL add_exec: got busy/valid/ctrl %b d1 %0d want 10010 d1 5", {busy_o, rsp_valid_o, alu_ctrl_o}, alu_data1_o);
        end
        tick();
        n_checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_err_o} !== 3'b100 || rsp_data_o !== 32'd12) begin
            n_fail++; $display("FAIL add_rsp: got v/id/err %b data %0d want 100 data 12", {rsp_valid_o, rsp_id_o, rsp_err_o}, rsp_data_o);
        end
        tick();
        n_checks++;
        if ({rsp_valid_o, busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL add_done: got %b want 00", {rsp_valid_o, busy_o});
        end
    endtask

    task automatic test_mul;
        req1_valid_i = 1'b1; req1_op_i = 3'b100; req1_a_i = 32'd6; req1_b_i = 32'd7;
        #1;
        n_checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b01) begin
            n_fail++; $display("FAIL mul_ready: got %b want 01", {req0_ready_o, req1_ready_o});
        end
        tick();
        req1_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({alu_ctrl_o, rsp_valid_o, busy_o} !== 5'b100_01) begin
                n_fail++; $display("FAIL mul_hold cycle %0d: got ctrl/valid/busy %b want 10001", i, {alu_ctrl_o, rsp_valid_o, busy_o});
            end
            tick();
        end
        n_checks++;
        if ({rsp_valid_o, rsp_id_o} !== 2'b11 || rsp_data_o !== 32'd42) begin
            n_fail++; $display("FAIL mul_rsp: got v/id %b data %0d want 11 data 42", {rsp_valid_o, rsp_id_o}, rsp_data_o);
        end
        tick();
    endtask

    task automatic test_round_robin;
        logic             exp_id;
        logic [WIDTH-1:0] exp_data;
        req0_valid_i = 1'b1; req0_op_i = 3'b011; req0_a_i = 32'd10;  req0_b_i = 32'd3;
        req1_valid_i = 1'b1; req1_op_i = 3'b000; req1_a_i = 32'hF0;  req1_b_i = 32'h0F;
        for (int k = 0; k < 4; k++) begin
            exp_id   = (k % 2) != 0;
            exp_data = exp_id ? 32'hFF : 32'd7;
            #1;
            n_checks++;
            if ({req1_ready_o, req0_ready_o} !== (exp_id ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL rr_grant %0d: got r1r0 %b want id %0d", k, {req1_ready_o, req0_ready_o}, exp_id);
            end
            tick();
            tick();
            n_checks++;
            if (rsp_valid_o !== 1'b1 || rsp_id_o !== exp_id || rsp_data_o !== exp_data || {req0_ready_o, req1_ready_o} !== 2'b00) begin
                n_fail++; $display("FAIL rr_rsp %0d: got v %b id %b data %0h ready %b want v 1 id %b data %0h ready 00",
                                   k, rsp_valid_o, rsp_id_o, rsp_data_o, {req0_ready_o, req1_ready_o}, exp_id, exp_data);
            end
            tick();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    endtask

    task automatic test_backpressure;
        req0_valid_i = 1'b1; req0_op_i = 3'b010; req0_a_i = 32'd1; req0_b_i = 32'd2;
        rsp_ready_i = 1'b0;
        #1;
        n_checks++;
        if (req0_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_ready: got %b want 1", req0_ready_o);
        end
        tick();
        req1_valid_i = 1'b1; req1_op_i = 3'b000; req1_a_i = 32'd4; req1_b_i = 32'd8;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid_o, busy_o, req0_ready_o, req1_ready_o} !== 4'b1100 || rsp_data_o !== 32'd3 || rsp_id_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold cycle %0d: got v/busy/r0/r1 %b data %0d id %b want 1100 data 3 id 0",
                                   i, {rsp_valid_o, busy_o, req0_ready_o, req1_ready_o}, rsp_data_o, rsp_id_o);
            end
            tick();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        n_checks++;
        if ({rsp_valid_o, busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL bp_release: got %b want 00", {rsp_valid_o, busy_o});
        end
        tick();
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_single_transfer: got %b want 0", rsp_valid_o);
        end
    endtask

    task automatic test_reset_mid_op;
        req1_valid_i = 1'b1; req1_op_i = 3'b100; req1_a_i = 32'd6; req1_b_i = 32'd7;
        tick();
        req1_valid_i = 1'b0;
        tick();
        n_checks++;
        if ({alu_ctrl_o, busy_o} !== 4'b100_1) begin
            n_fail++; $display("FAIL rst_pre_exec: got %b want 1001", {alu_ctrl_o, busy_o});
        end
        #1 rst_i = 1'b1;
        #1;
        n_checks++;
        if ({busy_o, rsp_valid_o, alu_ctrl_o} !== 5'b0 || alu_data1_o !== '0 || alu_data2_o !== '0) begin
            n_fail++; $display("FAIL rst_async: got busy/valid/ctrl %b d1 %0h d2 %0h want 0",
                               {busy_o, rsp_valid_o, alu_ctrl_o}, alu_data1_o, alu_data2_o);
        end
        #1 rst_i = 1'b0;
        req0_valid_i = 1'b1; req0_op_i = 3'b010; req0_a_i = 32'd20; req0_b_i = 32'd23;
        req1_valid_i = 1'b1; req1_op_i = 3'b000; req1_a_i = 32'd1;  req1_b_i = 32'd2;
        #1;
        n_checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            n_fail++; $display("FAIL rst_first_grant: got %b want 10", {req0_ready_o, req1_ready_o});
        end
        tick();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_stale_rsp: got %b want 0", rsp_valid_o);
        end
        tick();
        n_checks++;
        if ({rsp_valid_o, rsp_id_o} !== 2'b10 || rsp_data_o !== 32'd43) begin
            n_fail++; $display("FAIL rst_after_rsp: got v/id %b data %0d want 10 data 43", {rsp_valid_o, rsp_id_o}, rsp_data_o);
        end
        tick();
    endtask

    task automatic test_illegal_op;
        req0_valid_i = 1'b1; req0_op_i = 3'b111; req0_a_i = 32'd9; req0_b_i = 32'd9;
        tick();
        req0_valid_i = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
        n_checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_id_o} !== 3'b110 || rsp_data_o !== '0) begin
            n_fail++; $display("FAIL illegal_rsp: got v/err/id %b data %0h want 110 data 0", {rsp_valid_o, rsp_err_o, rsp_id_o}, rsp_data_o);
        end
        n_checks++;
        if (alu_ctrl_o !== 3'b010 || alu_data1_o !== 32'd20) begin
            n_fail++; $display("FAIL illegal_alu_untouched: got ctrl %b d1 %0d want 010 d1 20", alu_ctrl_o, alu_data1_o);
        end
        tick();
`else
        n_checks++;
        if ({alu_ctrl_o, busy_o, rsp_valid_o} !== 5'b111_10) begin
            n_fail++; $display("FAIL illegal_forward: got ctrl/busy/valid %b want 11110", {alu_ctrl_o, busy_o, rsp_valid_o});
        end
        tick();
        n_checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_id_o} !== 3'b100) begin
            n_fail++; $display("FAIL illegal_no_err: got v/err/id %b want 100", {rsp_valid_o, rsp_err_o, rsp_id_o});
        end
        tick();
`endif
        req0_valid_i = 1'b1; req0_op_i = 3'b001; req0_a_i = 32'hC; req0_b_i = 32'hA;
        tick();
        req0_valid_i = 1'b0;
        tick();
        n_checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_id_o} !== 3'b100 || rsp_data_o !== 32'h8) begin
            n_fail++; $display("FAIL and_after_illegal: got v/err/id %b data %0h want 100 data 8", {rsp_valid_o, rsp_err_o, rsp_id_o}, rsp_data_o);
        end
        tick();
        n_checks++;
        if ({rsp_valid_o, busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL final_idle: got %b want 00", {rsp_valid_o, busy_o});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_illegal_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU instance (OR/AND/ADD/SUB/MUL, 3-bit control, 32-bit operands) between two requesters.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Drives the ALU from registered operands and holds MUL for a configurable number of cycles to meet multiplier timing.
- Returns each result through a single valid/ready response channel, tagged with the requester id.

Parameters:
MUL_CYCLES, 3, cycles the ALU inputs are held for op 3'b100 (MUL) before the result is captured; legal range 1..15
WIDTH, 32, operand/result width; must match the ALU

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active high
req0_valid_i  input  1  requester 0 has an operation
req0_ready_o  output  1  requester 0 operation accepted this cycle
req0_op_i  input  3  ALU control for requester 0 (000 OR, 001 AND, 010 ADD, 011 SUB, 100 MUL)
req0_a_i  input  WIDTH  operand 1, requester 0
req0_b_i  input  WIDTH  operand 2, requester 0
req1_valid_i / req1_ready_o / req1_op_i / req1_a_i / req1_b_i  same as above for requester 1
rsp_valid_o  output  1  result available
rsp_ready_i  input  1  consumer takes result
rsp_id_o  output  1  requester that issued the result
rsp_data_o  output  WIDTH  result
rsp_err_o  output  1  illegal op flag (see Optional Feature)
alu_data1_o  output  WIDTH  to ALU data1
alu_data2_o  output  WIDTH  to ALU data2
alu_ctrl_o  output  3  to ALU control
alu_data_i  input  WIDTH  from ALU data output
busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - State IDLE.
  - rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o all 0.
  - Operand/op registers 0, so alu_* outputs are 0.
  - last_grant = 1, so requester 0 wins the first arbitration.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, grant goes to the one not equal to last_grant.
  - reqN_ready_o is high combinationally only for the granted requester and only in IDLE. Both ready outputs are never high together.
  - On valid & ready: latch op, a, b and id into registers, load cnt = (op==100) ? MUL_CYCLES-1 : 0, set last_grant = id, and go to EXEC.
- EXEC:
  - alu_* outputs come from the registers, stable for the whole operation.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: capture alu_data_i into rsp_data_o, set rsp_id_o, and go to RESP.
- RESP:
  - rsp_valid_o = 1. rsp_data_o and rsp_id_o are held stable until rsp_ready_i is sampled high.
  - On that edge: rsp_valid_o goes to 0 and the state goes to IDLE.
  - No new request is accepted in the same cycle.
- Latency: request accepted in cycle T -> rsp_valid_o high from cycle T+2 (non-MUL) or T+1+MUL_CYCLES (MUL).
- Throughput: at most one operation every 3 cycles when the consumer is always ready.
- Requester stability: a requester may drop valid before it is granted; no state changes. Operands are sampled only at acceptance.
- Back-pressure: if rsp_ready_i stays low, the block stays in RESP indefinitely and both ready outputs stay low.
- Ops 101–111 without the macro: forwarded to the ALU unchanged; result is whatever the ALU returns (undefined); rsp_err_o = 0.
- Reset asserted mid-operation: the operation is discarded, all outputs return to their reset values asynchronously, and no response is issued for it.

Optional Feature:
ALU_ARB_OPCHECK_EN
- Defined: an accepted op in 101–111 skips EXEC and goes straight to RESP in the next cycle, with rsp_data_o = 0 and rsp_err_o = 1. The ALU outputs are not updated. For legal ops, rsp_err_o = 0.
- Undefined: rsp_err_o is tied 0 and all ops go through EXEC.

Test Plan:
- Req0 ADD a=5, b=7, consumer always ready -> req0_ready_o high in the acceptance cycle; rsp_valid_o 2 cycles later; rsp_data_o=12, rsp_id_o=0.
- Req1 MUL a=6, b=7, MUL_CYCLES=3 -> alu_ctrl_o=100 held 3 cycles; rsp_valid_o 4 cycles after acceptance; rsp_data_o=42, rsp_id_o=1.
- Both requesters valid continuously (req0 SUB 10-3, req1 OR 0xF0|0x0F) -> grants alternate 0,1,0,1; responses 7, 0xFF, 7, 0xFF with matching ids.
- rsp_ready_i held low 5 cycles after a result is ready -> rsp_valid_o and rsp_data_o stable throughout; both ready outputs stay low; one transfer completes when rsp_ready_i rises.
- rst_i pulsed during the 2nd EXEC cycle of a MUL -> outputs 0 immediately; the next request from req0 is granted first and completes normally.
- With ALU_ARB_OPCHECK_EN defined, req0 op=111 -> response 1 cycle after acceptance, rsp_err_o=1, rsp_data_o=0; a following AND 0xC & 0xA returns 0x8 with rsp_err_o=0.
